// File: rtl/y86_pkg.sv
// Shared constants and types for the SEQ Y86-64 stage sequencer.
// Holds the icode/condition/status encodings and the controller state enum.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
        S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational condition evaluation from {zf, sf, of} and ifun.
// Zero latency; no handshake.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf, sf, of, lt;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b1;
        case (ifun)
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle SEQ stage sequencer: one stage strobe per cycle, CC/cnd, status, data-memory handshake.
// 6 cycles per instruction, plus one per cycle mem_ack is withheld; optional timeout faults a stuck access.
module y86_seq_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             en_pc,
    output logic             mem_req,
    output logic [2:0]       cc,
    output logic             cnd,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    import y86_pkg::*;

    localparam int              TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit              TO_EN = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [2:0]       cc_q, stat_q, stat_d;
    logic             cnd_q, memop_q, cond_res;
    logic [CNT_W-1:0] ret_q;
    logic [TW-1:0]    tcnt_q;
    logic             retire, cc_ld, tcnt_inc;

    y86_cond_eval u_cond (
        .cc   (cc_q),
        .ifun (ifun),
        .cnd  (cond_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        retire   = 1'b0;
        cc_ld    = 1'b0;
        tcnt_inc = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                cc_ld   = (icode == I_OPQ);
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!memop_q) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ack) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (TO_EN && (tcnt_q == TLAST)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                if (icode == I_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // cnd samples cc_q before this edge's OPq update, so it always sees the pre-update flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q    <= 3'b000;
            cnd_q   <= 1'b1;
            stat_q  <= STAT_AOK;
            ret_q   <= '0;
            memop_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            stat_q <= stat_d;
            if (cc_ld) cc_q <= {alu_zf, alu_sf, alu_of};
            if (state_q == S_EXECUTE) begin
                cnd_q   <= ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cond_res : 1'b1;
                memop_q <= is_mem_icode(icode);
            end
            if (tcnt_inc) tcnt_q <= tcnt_q + TW'(1);
            else          tcnt_q <= '0;
            if (retire)   ret_q  <= ret_q + CNT_W'(1);
        end
    end

    assign en_fetch     = (state_q == S_FETCH);
    assign en_decode    = (state_q == S_DECODE);
    assign en_execute   = (state_q == S_EXECUTE);
    assign en_memory    = (state_q == S_MEMORY);
    assign en_writeback = (state_q == S_WRITEBACK);
    assign en_pc        = (state_q == S_PCUPD);
    assign mem_req      = (state_q == S_MEMORY) && memop_q;
    assign halted       = (state_q == S_HALT);
    assign cc           = cc_q;
    assign cnd          = cnd_q;
    assign stat         = stat_q;
    assign retired      = ret_q;

endmodule

// File: doc/y86_seq_controller.md
# y86_seq_controller

Multi-cycle stage sequencer for the SEQ Y86-64 core. It steps each instruction through fetch, decode, execute, memory, writeback and PC-update by pulsing one stage enable per cycle. It owns the architectural condition-code register and evaluates `cnd` for `cmovXX`/`jXX`. It also runs the data-memory request/acknowledge handshake and tracks processor status (`stat`) through halt or fault.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 16: maximum cycles to wait for `mem_ack`. 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  leave IDLE and begin fetching.
- `icode`, `ifun`  in  4 each  from fetch; stable from end of FETCH until PCUPD.
- `instr_valid`  in  1  fetch decoded a legal icode.
- `imem_error`  in  1  fetch address out of range.
- `alu_zf`, `alu_sf`, `alu_of`  in  1 each  flags of the current ALU result.
- `mem_ack`  in  1  data memory completes the request.
- `dmem_error`  in  1  qualifies `mem_ack` as a faulting access.
- `en_fetch`, `en_decode`, `en_execute`, `en_memory`, `en_writeback`, `en_pc`  out  1 each  one-hot stage strobes.
- `mem_req`  out  1  data memory request.
- `cc`  out  3  {zf, sf, of}, the registered condition codes.
- `cnd`  out  1  registered condition result.
- `stat`  out  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `halted`  out  1  controller in HALT.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Each state drives only its own `en_*` strobe. IDLE and HALT drive no strobe.
- IDLE to FETCH when `start`=1. `start` is ignored in every other state.
- FETCH:
  - `imem_error`=1 sets `stat`=ADR and goes to HALT.
  - Otherwise `instr_valid`=0 sets `stat`=INS and goes to HALT. `imem_error` has priority over `instr_valid`.
  - Otherwise goes to DECODE.
- DECODE goes to EXECUTE.
- EXECUTE:
  - `cnd` is latched from the current `cc` and `ifun` for icode 2 or 7. For any other icode, `cnd` is latched as 1.
  - If icode=6 (OPq), `cc` is loaded with {alu_zf, alu_sf, alu_of} at the end of the cycle. `cnd` therefore always uses the pre-update `cc`.
  - Goes to MEMORY.
- Condition functions, with sf^of:
  - 0: always 1.
  - 1 le: (sf^of)|zf.
  - 2 l: sf^of.
  - 3 e: zf.
  - 4 ne: ~zf.
  - 5 ge: ~(sf^of).
  - 6 g: ~(sf^of)&~zf.
  - 7–15: 1.
- MEMORY:
  - For icode 4, 5, 8, 9, A, B, `mem_req` is held high until `mem_ack`=1.
  - `mem_ack` with `dmem_error`=1 sets `stat`=ADR and goes to HALT.
  - `mem_ack` with `dmem_error`=0 goes to WRITEBACK.
  - Timeout, when enabled, sets `stat`=ADR and goes to HALT after `MEM_TIMEOUT` cycles with `mem_req` high and no ack.
  - For other icodes, no request is made and the next state is WRITEBACK.
- WRITEBACK goes to PCUPD.
- PCUPD:
  - If icode=0 (halt), sets `stat`=HLT and goes to HALT. `retired` is not incremented.
  - Otherwise increments `retired` (wraps modulo 2^CNT_W) and goes to FETCH.
- HALT is terminal until reset. `halted`=1.
- `mem_ack` outside MEMORY, or while `mem_req`=0, is ignored.

## Timing
- Reset values:
  - state IDLE; all `en_*` 0; `mem_req` 0.
  - `cc`=3'b000; `cnd`=1; `stat`=AOK.
  - `halted`=0; `retired`=0; timeout counter 0.
- Reset asserted mid-instruction returns to IDLE immediately and asynchronously. No partial CC update survives.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- Throughput:
  - 6 cycles per non-memory instruction.
  - 6+N cycles for a memory instruction acked N cycles after `mem_req` rises. N=0 means ack in the first MEMORY cycle.
- `mem_req` deasserts in the cycle after `mem_ack` is sampled.
- `stat` and `halted` update on the same edge that enters HALT.

## Structure
- `y86_pkg`:
  - icode constants (HALT=0 through POPQ=B).
  - condition-function constants.
  - stat encodings.
  - state enum.
- One sub-module, `y86_cond_eval`: combinational (cc, ifun) to cnd. It is shared with the execute stage so the condition logic is not duplicated.

## Test plan
- Reset, then `start`, then icode 6 with alu_zf=1, sf=0, of=0 → strobes fetch…pc on cycles 1–6; `cc`=3'b100 after EXECUTE; `retired`=1.
- `cc`=3'b010 (sf=1), then icode 7 ifun 2 (jl) → `cnd`=1. Same with ifun 5 (jge) → `cnd`=0.
- icode 5 with `mem_ack` delayed 3 cycles → `mem_req` high exactly 4 cycles; instruction takes 9 cycles.
- icode 8 acked with `dmem_error`=1 → `stat`=3, `halted`=1, `retired` unchanged; later `start` ignored.
- FETCH with `instr_valid`=0 → `stat`=4. Icode 0 → `stat`=2 after PCUPD. `MEM_TIMEOUT`=4 with no ack → `stat`=3 after 4 MEMORY cycles.
- Assert `rst_n`=0 during MEMORY with `mem_req` high → `mem_req` and all strobes 0 immediately; `cc`=0; state IDLE.
